mlsu_req_issue: RTL and testbench

// - Upstream neighbour of the matrix LSU. Accepts memory requests from the sequencer and issues them to the
//   LSU request port through a one-entry output register.
// - Enforces memory-direction ordering: loads and stores are never in flight together.
// - Tracks up to NrOutstanding in-flight requests in issue order and retires them in order to the sequencer,

---
 rtl/mlsu_req_issue_pkg.sv | 34 +++
 rtl/mlsu_req_issue_if.sv | 50 +++++
 rtl/mlsu_inorder_tracker.sv | 119 +++++++++++
 rtl/mlsu_req_issue.sv | 106 ++++++++++
 tb/tb_mlsu_req_issue.sv | 343 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mlsu_req_issue_pkg.sv
//==============================================================================
// Module      : mlsu_req_issue_pkg
// Description : Shared types for the matrix-LSU request issue stage.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package mlsu_req_issue_pkg;

    localparam int ID_WIDTH               = 3;
    localparam int DEFAULT_NR_OUTSTANDING = 4;

    typedef logic [ID_WIDTH-1:0] vid_t;

    typedef struct packed {
        vid_t reqId;
        logic isLoad;
    } pe_req_t;

    typedef enum logic [1:0] {
        DIR_IDLE = 2'd0,
        DIR_LD   = 2'd1,
        DIR_ST   = 2'd2
    } mlsu_issue_dir_e;

    typedef struct packed {
        vid_t id;
        logic is_load;
        logic done;
    } issue_entry_t;

endpackage

`default_nettype wire

// File: rtl/mlsu_req_issue_if.sv
//==============================================================================
// Module      : mlsu_req_issue_if
// Description : Sequencer / LSU / completion bundle of the request issue stage.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface mlsu_req_issue_if
    import mlsu_req_issue_pkg::*;
#(
    parameter int NR_OUTSTANDING = DEFAULT_NR_OUTSTANDING
) ();

    logic                                    seq_req_valid_i;
    logic                                    seq_req_ready_o;
    pe_req_t                                 seq_req_i;
    logic                                    pe_req_valid_o;
    logic                                    pe_req_ready_i;
    pe_req_t                                 pe_req_o;
    logic                                    load_resp_valid_i;
    vid_t                                    load_resp_id_i;
    logic                                    store_resp_valid_i;
    vid_t                                    store_resp_id_i;
    logic                                    cmpl_valid_o;
    logic                                    cmpl_ready_i;
    vid_t                                    cmpl_id_o;
    logic                                    cmpl_is_load_o;
    logic [$clog2(NR_OUTSTANDING+1)-1:0]     inflight_cnt_o;
    logic                                    err_o;

    // Environment side (sequencer, LSU, completion consumer)
    modport master (
        output seq_req_valid_i, seq_req_i, pe_req_ready_i,
               load_resp_valid_i, load_resp_id_i, store_resp_valid_i, store_resp_id_i,
               cmpl_ready_i,
        input  seq_req_ready_o, pe_req_valid_o, pe_req_o, cmpl_valid_o, cmpl_id_o,
               cmpl_is_load_o, inflight_cnt_o, err_o
    );

    modport slave (
        input  seq_req_valid_i, seq_req_i, pe_req_ready_i,
               load_resp_valid_i, load_resp_id_i, store_resp_valid_i, store_resp_id_i,
               cmpl_ready_i,
        output seq_req_ready_o, pe_req_valid_o, pe_req_o, cmpl_valid_o, cmpl_id_o,
               cmpl_is_load_o, inflight_cnt_o, err_o
    );

endinterface

`default_nettype wire

// File: rtl/mlsu_inorder_tracker.sv
//==============================================================================
// Module      : mlsu_inorder_tracker
// Description : Circular in-flight table; marks completions, retires in order.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mlsu_inorder_tracker
    import mlsu_req_issue_pkg::*;
#(
    parameter  int NR_OUTSTANDING = DEFAULT_NR_OUTSTANDING,
    localparam int IDX_W          = $clog2(NR_OUTSTANDING),
    localparam int CNT_W          = IDX_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             alloc_valid_i,
    input  vid_t             alloc_id_i,
    input  logic             alloc_is_load_i,
    input  logic             pend_i,
    input  logic             load_resp_valid_i,
    input  vid_t             load_resp_id_i,
    input  logic             store_resp_valid_i,
    input  vid_t             store_resp_id_i,
    input  logic             cmpl_ready_i,
    output logic             cmpl_valid_o,
    output vid_t             cmpl_id_o,
    output logic             cmpl_is_load_o,
    output logic             full_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic             err_o
);

    issue_entry_t      r_table [NR_OUTSTANDING];
    logic [CNT_W-1:0]  r_head;
    logic [CNT_W-1:0]  r_tail;
    logic              r_err;

    logic [CNT_W-1:0]  w_cnt;
    logic [CNT_W-1:0]  w_issued;
    logic [IDX_W-1:0]  w_head_idx;
    logic [IDX_W-1:0]  w_tail_idx;
    logic [IDX_W-1:0]  w_scan_idx;
    logic [IDX_W-1:0]  w_ld_idx;
    logic [IDX_W-1:0]  w_st_idx;
    logic              w_ld_hit;
    logic              w_st_hit;
    logic              w_retire;

    assign w_head_idx = r_head[IDX_W-1:0];
    assign w_tail_idx = r_tail[IDX_W-1:0];
    assign w_cnt      = r_tail - r_head;
    // The youngest entry is not matchable while it still sits in the output register
    assign w_issued   = w_cnt - CNT_W'(pend_i);

    assign full_o         = (w_head_idx == w_tail_idx) && (r_head[IDX_W] != r_tail[IDX_W]);
    assign cnt_o          = w_cnt;
    assign err_o          = r_err;
    assign cmpl_valid_o   = r_table[w_head_idx].done;
    assign cmpl_id_o      = r_table[w_head_idx].id;
    assign cmpl_is_load_o = r_table[w_head_idx].is_load;
    assign w_retire       = cmpl_valid_o && cmpl_ready_i;

    // Scan oldest-first so duplicate ids resolve to the oldest outstanding entry
    always_comb begin
        w_ld_hit   = 1'b0;
        w_ld_idx   = '0;
        w_st_hit   = 1'b0;
        w_st_idx   = '0;
        w_scan_idx = '0;
        for (int k = 0; k < NR_OUTSTANDING; k++) begin
            w_scan_idx = w_head_idx + IDX_W'(k);
            if ((CNT_W'(k) < w_issued) && !r_table[w_scan_idx].done) begin
                if (!w_ld_hit && load_resp_valid_i && r_table[w_scan_idx].is_load &&
                    (r_table[w_scan_idx].id == load_resp_id_i)) begin
                    w_ld_hit = 1'b1;
                    w_ld_idx = w_scan_idx;
                end
                if (!w_st_hit && store_resp_valid_i && !r_table[w_scan_idx].is_load &&
                    (r_table[w_scan_idx].id == store_resp_id_i)) begin
                    w_st_hit = 1'b1;
                    w_st_idx = w_scan_idx;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_head <= '0;
            r_tail <= '0;
            r_err  <= 1'b0;
            for (int i = 0; i < NR_OUTSTANDING; i++) begin
                r_table[i] <= '0;
            end
        end else begin
            if (w_ld_hit) begin
                r_table[w_ld_idx].done <= 1'b1;
            end
            if (w_st_hit) begin
                r_table[w_st_idx].done <= 1'b1;
            end
            if ((load_resp_valid_i && !w_ld_hit) || (store_resp_valid_i && !w_st_hit)) begin
                r_err <= 1'b1;
            end
            if (w_retire) begin
                r_table[w_head_idx].done <= 1'b0;
                r_head                   <= r_head + CNT_W'(1);
            end
            if (alloc_valid_i) begin
                r_table[w_tail_idx] <= '{id: alloc_id_i, is_load: alloc_is_load_i, done: 1'b0};
                r_tail              <= r_tail + CNT_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mlsu_req_issue.sv
//==============================================================================
// Module      : mlsu_req_issue
// Description : Direction-ordered request issue with output register and
//               in-order completion tracking for the matrix LSU.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mlsu_req_issue
    import mlsu_req_issue_pkg::*;
#(
    parameter int NR_OUTSTANDING = DEFAULT_NR_OUTSTANDING
) (
    input  logic             clk_i,
    input  logic             rst_i,
    mlsu_req_issue_if.slave  bus
);

    localparam int CNT_W = $clog2(NR_OUTSTANDING) + 1;

    mlsu_issue_dir_e   r_dir;
    logic              r_pe_valid;
    pe_req_t           r_pe_req;

    logic              w_dir_ok;
    logic              w_ready;
    logic              w_accept;
    logic              w_full;
    logic              w_retire;
    logic              w_cmpl_valid;
    logic [CNT_W-1:0]  w_cnt;

    always_comb begin
        w_dir_ok = 1'b0;
        case (r_dir)
            DIR_IDLE: w_dir_ok = 1'b1;
            DIR_LD:   w_dir_ok = bus.seq_req_i.isLoad;
            DIR_ST:   w_dir_ok = !bus.seq_req_i.isLoad;
            default:  w_dir_ok = 1'b0;
        endcase
    end

    // Gated by reset so every output reads 0 while reset is held
    assign w_ready  = !rst_i && !w_full && w_dir_ok && (!r_pe_valid || bus.pe_req_ready_i);
    assign w_accept = w_ready && bus.seq_req_valid_i;
    assign w_retire = w_cmpl_valid && bus.cmpl_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_dir      <= DIR_IDLE;
            r_pe_valid <= 1'b0;
            r_pe_req   <= '0;
        end else begin
            if (w_accept) begin
                r_pe_valid <= 1'b1;
                r_pe_req   <= bus.seq_req_i;
            end else if (bus.pe_req_ready_i) begin
                r_pe_valid <= 1'b0;
            end
            case (r_dir)
                DIR_IDLE: begin
                    if (w_accept) begin
                        r_dir <= bus.seq_req_i.isLoad ? DIR_LD : DIR_ST;
                    end
                end
                DIR_LD, DIR_ST: begin
                    if (w_retire && (w_cnt == CNT_W'(1)) && !w_accept) begin
                        r_dir <= DIR_IDLE;
                    end
                end
                default: r_dir <= DIR_IDLE;
            endcase
        end
    end

    mlsu_inorder_tracker #(
        .NR_OUTSTANDING (NR_OUTSTANDING)
    ) u_tracker (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .alloc_valid_i      (w_accept),
        .alloc_id_i         (bus.seq_req_i.reqId),
        .alloc_is_load_i    (bus.seq_req_i.isLoad),
        .pend_i             (r_pe_valid),
        .load_resp_valid_i  (bus.load_resp_valid_i),
        .load_resp_id_i     (bus.load_resp_id_i),
        .store_resp_valid_i (bus.store_resp_valid_i),
        .store_resp_id_i    (bus.store_resp_id_i),
        .cmpl_ready_i       (bus.cmpl_ready_i),
        .cmpl_valid_o       (w_cmpl_valid),
        .cmpl_id_o          (bus.cmpl_id_o),
        .cmpl_is_load_o     (bus.cmpl_is_load_o),
        .full_o             (w_full),
        .cnt_o              (w_cnt),
        .err_o              (bus.err_o)
    );

    assign bus.seq_req_ready_o = w_ready;
    assign bus.pe_req_valid_o  = r_pe_valid;
    assign bus.pe_req_o        = r_pe_req;
    assign bus.cmpl_valid_o    = w_cmpl_valid;
    assign bus.inflight_cnt_o  = w_cnt;

endmodule

`default_nettype wire

// File: tb/tb_mlsu_req_issue.sv
//==============================================================================
// Module      : tb_mlsu_req_issue
// Description : Directed scenarios plus randomized run against a queue model.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mlsu_req_issue;
    import mlsu_req_issue_pkg::*;

    localparam int N = 4;

    typedef struct packed {
        logic [2:0] id;
        logic       ld;
        logic       done;
    } m_ent_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mlsu_req_issue_if #(.NR_OUTSTANDING(N)) bus ();

    mlsu_req_issue #(.NR_OUTSTANDING(N)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.seq_req_valid_i    = 1'b0;
        bus.seq_req_i          = '0;
        bus.pe_req_ready_i     = 1'b0;
        bus.load_resp_valid_i  = 1'b0;
        bus.load_resp_id_i     = '0;
        bus.store_resp_valid_i = 1'b0;
        bus.store_resp_id_i    = '0;
        bus.cmpl_ready_i       = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic offer(input logic [2:0] id, input logic ld);
        bus.seq_req_valid_i  = 1'b1;
        bus.seq_req_i.reqId  = id;
        bus.seq_req_i.isLoad = ld;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        checks++; if (bus.pe_req_valid_o !== 1'b0) begin errors++; $display("FAIL reset_pe_valid got %0b exp 0", bus.pe_req_valid_o); end
        checks++; if (bus.seq_req_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b exp 0", bus.seq_req_ready_o); end
        checks++; if (bus.cmpl_valid_o !== 1'b0) begin errors++; $display("FAIL reset_cmpl_valid got %0b exp 0", bus.cmpl_valid_o); end
        checks++; if (bus.inflight_cnt_o !== 3'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", bus.inflight_cnt_o); end
        checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %0b exp 0", bus.err_o); end
        rst = 1'b0;
        tick();
        @(negedge clk);
        checks++; if (bus.seq_req_ready_o !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %0b exp 1", bus.seq_req_ready_o); end
        tick();
    endtask

    task automatic test_in_order();
        logic [2:0] order [4];
        int         exp_next;
        order = '{3'd2, 3'd0, 3'd3, 3'd1};
        do_reset();
        bus.pe_req_ready_i = 1'b1;
        bus.cmpl_ready_i   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            offer(3'(i), 1'b1);
            @(negedge clk);
            checks++; if (bus.seq_req_ready_o !== 1'b1) begin errors++; $display("FAIL inorder_accept%0d got %0b exp 1", i, bus.seq_req_ready_o); end
            tick();
            checks++; if (bus.pe_req_valid_o !== 1'b1 || bus.pe_req_o.reqId !== 3'(i)) begin errors++; $display("FAIL inorder_issue%0d got v=%0b id=%0d exp v=1 id=%0d", i, bus.pe_req_valid_o, bus.pe_req_o.reqId, i); end
        end
        bus.seq_req_valid_i = 1'b0;
        tick();
        checks++; if (bus.inflight_cnt_o !== 3'd4 || bus.pe_req_valid_o !== 1'b0) begin errors++; $display("FAIL inorder_cnt4 got cnt=%0d v=%0b exp cnt=4 v=0", bus.inflight_cnt_o, bus.pe_req_valid_o); end
        exp_next = 0;
        for (int c = 0; c < 20; c++) begin
            bus.load_resp_valid_i = (c < 4);
            if (c < 4) bus.load_resp_id_i = order[c];
            @(negedge clk);
            if (bus.cmpl_valid_o === 1'b1) begin
                checks++; if (bus.cmpl_id_o !== 3'(exp_next) || bus.cmpl_is_load_o !== 1'b1) begin errors++; $display("FAIL inorder_retire got id=%0d ld=%0b exp id=%0d ld=1", bus.cmpl_id_o, bus.cmpl_is_load_o, exp_next); end
                exp_next++;
            end
            tick();
        end
        bus.load_resp_valid_i = 1'b0;
        checks++; if (exp_next != 4) begin errors++; $display("FAIL inorder_retire_count got %0d exp 4", exp_next); end
        checks++; if (bus.inflight_cnt_o !== 3'd0) begin errors++; $display("FAIL inorder_cnt0 got %0d exp 0", bus.inflight_cnt_o); end
    endtask

    task automatic test_dir_order();
        do_reset();
        bus.pe_req_ready_i = 1'b1;
        offer(3'd5, 1'b1);
        tick();
        offer(3'd6, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (bus.seq_req_ready_o !== 1'b0) begin errors++; $display("FAIL dir_stall%0d got %0b exp 0", k, bus.seq_req_ready_o); end
            tick();
        end
        bus.load_resp_valid_i = 1'b1;
        bus.load_resp_id_i    = 3'd5;
        tick();
        bus.load_resp_valid_i = 1'b0;
        tick();
        bus.cmpl_ready_i = 1'b1;
        @(negedge clk);
        checks++; if (bus.cmpl_valid_o !== 1'b1 || bus.cmpl_id_o !== 3'd5 || bus.seq_req_ready_o !== 1'b0) begin errors++; $display("FAIL dir_retire got v=%0b id=%0d rdy=%0b exp v=1 id=5 rdy=0", bus.cmpl_valid_o, bus.cmpl_id_o, bus.seq_req_ready_o); end
        tick();
        bus.cmpl_ready_i = 1'b0;
        @(negedge clk);
        checks++; if (bus.seq_req_ready_o !== 1'b1 || bus.inflight_cnt_o !== 3'd0) begin errors++; $display("FAIL dir_after_retire got rdy=%0b cnt=%0d exp rdy=1 cnt=0", bus.seq_req_ready_o, bus.inflight_cnt_o); end
        checks++; if (dut.r_dir !== DIR_IDLE) begin errors++; $display("FAIL dir_idle got %0d exp %0d", dut.r_dir, DIR_IDLE); end
        tick();
        bus.seq_req_valid_i = 1'b0;
        @(negedge clk);
        checks++; if (bus.pe_req_valid_o !== 1'b1 || bus.pe_req_o !== pe_req_t'({3'd6, 1'b0})) begin errors++; $display("FAIL dir_store_issue got v=%0b req=%0h exp v=1 req=c", bus.pe_req_valid_o, bus.pe_req_o); end
        checks++; if (dut.r_dir !== DIR_ST) begin errors++; $display("FAIL dir_st got %0d exp %0d", dut.r_dir, DIR_ST); end
        tick();
    endtask

    task automatic test_full();
        do_reset();
        bus.pe_req_ready_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            offer(3'(i), 1'b1);
            tick();
        end
        offer(3'd5, 1'b1);
        tick();
        @(negedge clk);
        checks++; if (bus.inflight_cnt_o !== 3'd4 || bus.seq_req_ready_o !== 1'b0) begin errors++; $display("FAIL full_block got cnt=%0d rdy=%0b exp cnt=4 rdy=0", bus.inflight_cnt_o, bus.seq_req_ready_o); end
        tick();
        bus.load_resp_valid_i = 1'b1;
        bus.load_resp_id_i    = 3'd1;
        tick();
        bus.load_resp_valid_i = 1'b0;
        @(negedge clk);
        checks++; if (bus.cmpl_valid_o !== 1'b1 || bus.seq_req_ready_o !== 1'b0) begin errors++; $display("FAIL full_held got v=%0b rdy=%0b exp v=1 rdy=0", bus.cmpl_valid_o, bus.seq_req_ready_o); end
        tick();
        bus.cmpl_ready_i = 1'b1;
        @(negedge clk);
        checks++; if (bus.cmpl_valid_o !== 1'b1 || bus.seq_req_ready_o !== 1'b0) begin errors++; $display("FAIL full_same_cycle got v=%0b rdy=%0b exp v=1 rdy=0", bus.cmpl_valid_o, bus.seq_req_ready_o); end
        tick();
        bus.cmpl_ready_i = 1'b0;
        @(negedge clk);
        checks++; if (bus.seq_req_ready_o !== 1'b1 || bus.inflight_cnt_o !== 3'd3) begin errors++; $display("FAIL full_next_cycle got rdy=%0b cnt=%0d exp rdy=1 cnt=3", bus.seq_req_ready_o, bus.inflight_cnt_o); end
        tick();
        bus.seq_req_valid_i = 1'b0;
        @(negedge clk);
        checks++; if (bus.inflight_cnt_o !== 3'd4 || bus.pe_req_o.reqId !== 3'd5) begin errors++; $display("FAIL full_refill got cnt=%0d id=%0d exp cnt=4 id=5", bus.inflight_cnt_o, bus.pe_req_o.reqId); end
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.cmpl_ready_i = 1'b1;
        offer(3'd2, 1'b0);
        tick();
        offer(3'd3, 1'b0);
        for (int k = 0; k < 3; k++) begin
            bus.store_resp_valid_i = (k == 0);
            bus.store_resp_id_i    = 3'd2;
            @(negedge clk);
            checks++; if (bus.pe_req_valid_o !== 1'b1 || bus.pe_req_o !== pe_req_t'({3'd2, 1'b0}) || bus.seq_req_ready_o !== 1'b0) begin errors++; $display("FAIL bp_hold%0d got v=%0b req=%0h rdy=%0b exp v=1 req=4 rdy=0", k, bus.pe_req_valid_o, bus.pe_req_o, bus.seq_req_ready_o); end
            tick();
        end
        bus.store_resp_valid_i = 1'b0;
        @(negedge clk);
        checks++; if (bus.err_o !== 1'b1 || bus.inflight_cnt_o !== 3'd1 || bus.cmpl_valid_o !== 1'b0) begin errors++; $display("FAIL bp_unissued_resp got err=%0b cnt=%0d v=%0b exp err=1 cnt=1 v=0", bus.err_o, bus.inflight_cnt_o, bus.cmpl_valid_o); end
        bus.pe_req_ready_i = 1'b1;
        #1;
        checks++; if (bus.seq_req_ready_o !== 1'b1) begin errors++; $display("FAIL bp_release got rdy=%0b exp 1", bus.seq_req_ready_o); end
        tick();
        bus.seq_req_valid_i = 1'b0;
        @(negedge clk);
        checks++; if (bus.pe_req_valid_o !== 1'b1 || bus.pe_req_o.reqId !== 3'd3 || bus.inflight_cnt_o !== 3'd2) begin errors++; $display("FAIL bp_next got v=%0b id=%0d cnt=%0d exp v=1 id=3 cnt=2", bus.pe_req_valid_o, bus.pe_req_o.reqId, bus.inflight_cnt_o); end
        tick();
    endtask

    task automatic test_err_reset();
        do_reset();
        bus.pe_req_ready_i = 1'b1;
        bus.cmpl_ready_i   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            offer(3'(i), 1'b1);
            tick();
        end
        bus.seq_req_valid_i = 1'b0;
        tick();
        bus.store_resp_valid_i = 1'b1;
        bus.store_resp_id_i    = 3'd7;
        tick();
        bus.store_resp_valid_i = 1'b0;
        @(negedge clk);
        checks++; if (bus.err_o !== 1'b1 || bus.inflight_cnt_o !== 3'd3 || bus.cmpl_valid_o !== 1'b0) begin errors++; $display("FAIL err_set got err=%0b cnt=%0d v=%0b exp err=1 cnt=3 v=0", bus.err_o, bus.inflight_cnt_o, bus.cmpl_valid_o); end
        tick();
        tick();
        checks++; if (bus.err_o !== 1'b1) begin errors++; $display("FAIL err_sticky got %0b exp 1", bus.err_o); end
        rst = 1'b1;
        #1;
        checks++; if (bus.pe_req_valid_o !== 1'b0 || bus.seq_req_ready_o !== 1'b0 || bus.cmpl_valid_o !== 1'b0 || bus.err_o !== 1'b0) begin errors++; $display("FAIL midrst_flags got pv=%0b rdy=%0b cv=%0b err=%0b exp all 0", bus.pe_req_valid_o, bus.seq_req_ready_o, bus.cmpl_valid_o, bus.err_o); end
        checks++; if (bus.inflight_cnt_o !== 3'd0 || bus.pe_req_o !== '0 || bus.cmpl_id_o !== '0 || bus.cmpl_is_load_o !== 1'b0) begin errors++; $display("FAIL midrst_data got cnt=%0d req=%0h id=%0d ld=%0b exp all 0", bus.inflight_cnt_o, bus.pe_req_o, bus.cmpl_id_o, bus.cmpl_is_load_o); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_random();
        m_ent_t   q[$];
        bit       pend;
        pe_req_t  pend_req;
        bit       m_err;
        bit       exp_ready;
        bit       exp_cv;
        bit       accept;
        bit       found;
        int       n_iss;
        int       k;
        do_reset();
        pend  = 1'b0;
        m_err = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            bus.seq_req_valid_i  = ($urandom_range(0, 3) != 0);
            bus.seq_req_i.reqId  = 3'($urandom_range(0, 3));
            bus.seq_req_i.isLoad = (((cyc / 50) % 2) == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) == 0);
            bus.pe_req_ready_i   = ($urandom_range(0, 3) != 0);
            bus.cmpl_ready_i     = ($urandom_range(0, 2) != 0);
            bus.load_resp_valid_i  = 1'b0;
            bus.store_resp_valid_i = 1'b0;
            n_iss = q.size() - (pend ? 1 : 0);
            if (n_iss > 0 && $urandom_range(0, 1) == 1) begin
                k = $urandom_range(0, n_iss - 1);
                if (!q[k].done) begin
                    if (q[k].ld) begin
                        bus.load_resp_valid_i = 1'b1;
                        bus.load_resp_id_i    = q[k].id;
                    end else begin
                        bus.store_resp_valid_i = 1'b1;
                        bus.store_resp_id_i    = q[k].id;
                    end
                end
            end
            @(negedge clk);
            // All in-flight entries share one direction; an empty table takes either
            exp_ready = (q.size() < N) && (q.size() == 0 || q[0].ld == bus.seq_req_i.isLoad) && (!pend || bus.pe_req_ready_i);
            exp_cv    = (q.size() > 0) && q[0].done;
            checks++; if (bus.seq_req_ready_o !== exp_ready) begin errors++; $display("FAIL rnd_ready cyc%0d got %0b exp %0b", cyc, bus.seq_req_ready_o, exp_ready); end
            checks++; if (bus.pe_req_valid_o !== pend) begin errors++; $display("FAIL rnd_pe_valid cyc%0d got %0b exp %0b", cyc, bus.pe_req_valid_o, pend); end
            if (pend) begin
                checks++; if (bus.pe_req_o !== pend_req) begin errors++; $display("FAIL rnd_pe_req cyc%0d got %0h exp %0h", cyc, bus.pe_req_o, pend_req); end
            end
            checks++; if (bus.cmpl_valid_o !== exp_cv) begin errors++; $display("FAIL rnd_cmpl_valid cyc%0d got %0b exp %0b", cyc, bus.cmpl_valid_o, exp_cv); end
            if (exp_cv) begin
                checks++; if (bus.cmpl_id_o !== q[0].id || bus.cmpl_is_load_o !== q[0].ld) begin errors++; $display("FAIL rnd_cmpl cyc%0d got id=%0d ld=%0b exp id=%0d ld=%0b", cyc, bus.cmpl_id_o, bus.cmpl_is_load_o, q[0].id, q[0].ld); end
            end
            checks++; if (bus.inflight_cnt_o !== 3'(q.size())) begin errors++; $display("FAIL rnd_cnt cyc%0d got %0d exp %0d", cyc, bus.inflight_cnt_o, q.size()); end
            checks++; if (bus.err_o !== m_err) begin errors++; $display("FAIL rnd_err cyc%0d got %0b exp %0b", cyc, bus.err_o, m_err); end
            accept = bus.seq_req_valid_i && exp_ready;
            if (bus.load_resp_valid_i) begin
                found = 1'b0;
                for (int j = 0; j < n_iss; j++) begin
                    if (!found && q[j].ld && !q[j].done && q[j].id == bus.load_resp_id_i) begin
                        q[j].done = 1'b1;
                        found     = 1'b1;
                    end
                end
                if (!found) m_err = 1'b1;
            end
            if (bus.store_resp_valid_i) begin
                found = 1'b0;
                for (int j = 0; j < n_iss; j++) begin
                    if (!found && !q[j].ld && !q[j].done && q[j].id == bus.store_resp_id_i) begin
                        q[j].done = 1'b1;
                        found     = 1'b1;
                    end
                end
                if (!found) m_err = 1'b1;
            end
            if (exp_cv && bus.cmpl_ready_i) void'(q.pop_front());
            if (accept) begin
                q.push_back('{id: bus.seq_req_i.reqId, ld: bus.seq_req_i.isLoad, done: 1'b0});
                pend     = 1'b1;
                pend_req = bus.seq_req_i;
            end else if (bus.pe_req_ready_i) begin
                pend = 1'b0;
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        idle_inputs();
        test_reset();
        test_in_order();
        test_dir_order();
        test_full();
        test_backpressure();
        test_err_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
